// File: rtl/datadist_pkg.sv
// Shared constants and types for the datadist 1-to-4 distributor.
// Slot count, select width and drop counter width live here so the top
// and slot modules agree on sizing.
package datadist_pkg;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int DROPW = 8;

  typedef logic [SELW-1:0] sel_t;
endpackage

// File: rtl/datadist_slot.sv
// One output slot: DW-bit data register plus sticky valid flag.
// Latency: load visible one edge after accept; ack clears valid at the same edge.
// Backpressure: holds its word until acked; a same-cycle load wins over ack (pass-through).
module datadist_slot
  import datadist_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          ack,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y,
  output logic          v
);

  // Load takes priority so an ack on a full slot can be refilled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      v <= 1'b0;
    end else if (load) begin
      y <= d;
      v <= 1'b1;
    end else if (ack) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/datadist.sv
// Registered 1-to-4 data distributor steered by select pins or a round-robin pointer.
// Latency: accepted word appears in its slot one clock edge after the accept.
// Backpressure: rdyout drops when strobed off or the target slot is full and not acked; refused offers are counted.
module datadist
  import datadist_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clkin,
  input  logic             rstin,
  input  logic             ain,
  input  logic             bin,
  input  logic             gbin,
  input  logic             scanin,
  input  logic [DW-1:0]    din,
  input  logic             vin,
  output logic             rdyout,
  output logic [SELW-1:0]  selout,
  input  logic             ack0in,
  input  logic             ack1in,
  input  logic             ack2in,
  input  logic             ack3in,
  output logic [DW-1:0]    y0out,
  output logic [DW-1:0]    y1out,
  output logic [DW-1:0]    y2out,
  output logic [DW-1:0]    y3out,
  output logic             v0out,
  output logic             v1out,
  output logic             v2out,
  output logic             v3out,
  output logic [DROPW-1:0] dropout
);

  sel_t             ptr;
  sel_t             tgt;
  logic             accept;
  logic [NCH-1:0]   ack;
  logic [NCH-1:0]   v;
  logic [NCH-1:0]   load;
  logic [DW-1:0]    y [NCH];

  assign ack = {ack3in, ack2in, ack1in, ack0in};

  // Target decode, ready mux and per-slot load strobes.
  always_comb begin
    tgt    = scanin ? ptr : {bin, ain};
    rdyout = !gbin && (!v[tgt] || ack[tgt]);
    accept = vin && rdyout;
    load   = '0;
    load[tgt] = accept;
  end

  assign selout = tgt;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    datadist_slot #(.DW(DW)) u_slot (
      .clk  (clkin),
      .rst  (rstin),
      .load (load[k]),
      .ack  (ack[k] && v[k]),
      .d    (din),
      .y    (y[k]),
      .v    (v[k])
    );
  end

  // Scan pointer advances per accept in scan mode and parks at 0 otherwise.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      ptr <= '0;
    end else if (!scanin) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= sel_t'(ptr + 1'b1);
    end
  end

  // Saturating count of offers refused while valid.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      dropout <= '0;
    end else if (vin && !rdyout && (dropout != {DROPW{1'b1}})) begin
      dropout <= dropout + 1'b1;
    end
  end

  assign y0out = y[0];
  assign y1out = y[1];
  assign y2out = y[2];
  assign y3out = y[3];
  assign v0out = v[0];
  assign v1out = v[1];
  assign v2out = v[2];
  assign v3out = v[3];

endmodule
